// File: rtl/snk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snk_pkg
//  Description : Shared definitions for the snake body mover.
//                Direction codes, the opposite-direction helper, the FSM
//                state type, and segment pack/unpack helpers.
//                A segment is {x[BITS-1:0], y[BITS-1:0]}. The helpers work on
//                a 16-bit-per-axis container. Callers size-cast the result
//                down to their own BITS.
//  Revision    : 1.0 - initial release
// ============================================================================
package snk_pkg;

  localparam logic [1:0] DIR_UP = 2'b00;  // y-1
  localparam logic [1:0] DIR_DN = 2'b01;  // y+1
  localparam logic [1:0] DIR_LT = 2'b10;  // x-1
  localparam logic [1:0] DIR_RT = 2'b11;  // x+1

  localparam int SEG_MAX_BITS = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  // Opposite pairs differ only in bit 0 (UP/DN, LT/RT).
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  function automatic logic [2*SEG_MAX_BITS-1:0] seg_pack(
      input logic [SEG_MAX_BITS-1:0] x,
      input logic [SEG_MAX_BITS-1:0] y,
      input int                      bits);
    logic [2*SEG_MAX_BITS-1:0] r;
    r = ((2*SEG_MAX_BITS)'(x) << bits) | (2*SEG_MAX_BITS)'(y);
    return r;
  endfunction

  function automatic logic [SEG_MAX_BITS-1:0] seg_x(
      input logic [2*SEG_MAX_BITS-1:0] s,
      input int                        bits);
    return SEG_MAX_BITS'(s >> bits);
  endfunction

  function automatic logic [SEG_MAX_BITS-1:0] seg_y(
      input logic [2*SEG_MAX_BITS-1:0] s,
      input int                        bits);
    logic [2*SEG_MAX_BITS-1:0] m;
    m = ((2*SEG_MAX_BITS)'(1) << bits) - (2*SEG_MAX_BITS)'(1);
    return SEG_MAX_BITS'(s & m);
  endfunction

endpackage : snk_pkg
`default_nettype wire

// File: rtl/snk_next_pos.sv
`default_nettype none
// ============================================================================
//  Module      : snk_next_pos
//  Description : Combinational next-head calculator.
//                head_i     : current head segment {x,y}
//                dir_i      : requested direction
//                last_dir_i : direction of the last committed move
//                len_i      : current body length
//                cand_o     : candidate head after the move
//                eff_dir_o  : direction actually used (reversal guarded)
//                wall_hit_o : move leaves the grid (only when WRAP=0)
//  Revision    : 1.0 - initial release
// ============================================================================
module snk_next_pos
  import snk_pkg::*;
#(
  parameter int BITS = 4,
  parameter int WRAP = 0,
  parameter int IW   = 5
) (
  input  logic [2*BITS-1:0] head_i,
  input  logic [1:0]        dir_i,
  input  logic [1:0]        last_dir_i,
  input  logic [IW-1:0]     len_i,
  output logic [2*BITS-1:0] cand_o,
  output logic [1:0]        eff_dir_o,
  output logic              wall_hit_o
);

  localparam int              PW     = 2*SEG_MAX_BITS;
  localparam logic [BITS-1:0] C_MAX  = '1;
  localparam logic [BITS-1:0] C_INC  = BITS'(1);
  localparam logic [IW-1:0]   C_ONE  = IW'(1);
  localparam logic            C_KILL = (WRAP == 0);

  logic [BITS-1:0] w_x, w_y, w_nx, w_ny;
  logic            w_edge;

  always_comb begin
    // A one-segment snake has no neck, so it may turn back on itself.
    eff_dir_o = dir_i;
    if ((dir_i == dir_opposite(last_dir_i)) && (len_i > C_ONE)) begin
      eff_dir_o = last_dir_i;
    end

    w_x    = BITS'(seg_x(PW'(head_i), BITS));
    w_y    = BITS'(seg_y(PW'(head_i), BITS));
    w_nx   = w_x;
    w_ny   = w_y;
    w_edge = 1'b0;

    // Plain BITS-bit arithmetic gives the modular wrap for free.
    case (eff_dir_o)
      DIR_UP: begin w_ny = w_y - C_INC; w_edge = (w_y == '0);    end
      DIR_DN: begin w_ny = w_y + C_INC; w_edge = (w_y == C_MAX); end
      DIR_LT: begin w_nx = w_x - C_INC; w_edge = (w_x == '0);    end
      default: begin w_nx = w_x + C_INC; w_edge = (w_x == C_MAX); end
    endcase

    wall_hit_o = C_KILL && w_edge;
    cand_o     = (2*BITS)'(seg_pack(SEG_MAX_BITS'(w_nx), SEG_MAX_BITS'(w_ny), BITS));
  end

endmodule : snk_next_pos
`default_nettype wire

// File: rtl/snk_body.sv
`default_nettype none
// ============================================================================
//  Module      : snk_body
//  Description : Snake body buffer with step FSM.
//                Holds up to MAX_LEN segments (seg[0] = head). An accepted
//                step computes a candidate head. The candidate is then
//                scanned against the body one segment per cycle, and the
//                move commits by shifting the buffer.
//  Ports       : clk_i, rst_i          clock / sync active-high reset
//                step_i, dir_i, grow_i move request (sampled when ready_o)
//                ready_o               FSM idle in RUN
//                done_o, dead_o        1-cycle commit / death pulses
//                alive_o               low from death until reset
//                head_o, len_o         head segment and current length
//                rd_idx_i, rd_seg_o,   random-access body read port
//                rd_valid_o
//  Revision    : 1.0 - initial release
// ============================================================================
module snk_body
  import snk_pkg::*;
#(
  parameter int   BITS    = 4,
  parameter int   MAX_LEN = 16,
  parameter int   WRAP    = 0,
  parameter int   START_X = 2**(BITS-1),
  parameter int   START_Y = 2**(BITS-1),
  localparam int  IW      = $clog2(MAX_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic [1:0]        dir_i,
  input  logic              grow_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              dead_o,
  output logic              alive_o,
  output logic [2*BITS-1:0] head_o,
  output logic [IW-1:0]     len_o,
  input  logic [IW-1:0]     rd_idx_i,
  output logic [2*BITS-1:0] rd_seg_o,
  output logic              rd_valid_o
);

  localparam int            SW        = 2*BITS;
  localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IW-1:0] C_MAX_LEN = IW'(MAX_LEN);
  localparam logic [IW-1:0] C_ONE     = IW'(1);
  localparam logic [IW-1:0] C_ZERO    = '0;
  localparam logic [SW-1:0] C_START   =
      SW'(seg_pack(SEG_MAX_BITS'(START_X), SEG_MAX_BITS'(START_Y), BITS));

  logic [SW-1:0] seg_q [MAX_LEN];
  state_e        state_q, state_d;
  logic [IW-1:0] len_q, idx_q, limit_q;
  logic [1:0]    last_dir_q, eff_dir_q;
  logic [SW-1:0] cand_q;
  logic          grow_q, done_q, done_d, dead_q, dead_d;

  logic [SW-1:0] w_cand;
  logic [1:0]    w_eff_dir;
  logic          w_wall, w_grow, w_hit, w_last, w_accept, w_commit;
  logic [IW-1:0] w_limit;

  snk_next_pos #(
    .BITS (BITS),
    .WRAP (WRAP),
    .IW   (IW)
  ) u_next_pos (
    .head_i     (seg_q[0]),
    .dir_i      (dir_i),
    .last_dir_i (last_dir_q),
    .len_i      (len_q),
    .cand_o     (w_cand),
    .eff_dir_o  (w_eff_dir),
    .wall_hit_o (w_wall)
  );

  // The tail leaves its cell on a non-growing move, so it is excluded
  // from the collision scan in that case.
  assign w_grow  = grow_i && (len_q < C_MAX_LEN);
  assign w_limit = w_grow ? len_q : (len_q - C_ONE);
  assign w_hit   = (cand_q == seg_q[idx_q[AW-1:0]]);
  assign w_last  = (idx_q == (limit_q - C_ONE));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    dead_d   = 1'b0;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (step_i) begin
          if (w_wall) begin
            state_d = ST_DEAD;
            dead_d  = 1'b1;
          end else begin
            w_accept = 1'b1;
            state_d  = (w_limit == C_ZERO) ? ST_COMMIT : ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (w_hit) begin
          state_d = ST_DEAD;
          dead_d  = 1'b1;
        end else if (w_last) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_RUN;
      end
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q      <= C_ONE;
      last_dir_q <= DIR_RT;
      eff_dir_q  <= DIR_RT;
      cand_q     <= '0;
      grow_q     <= 1'b0;
      limit_q    <= '0;
      idx_q      <= '0;
    end else begin
      if (w_accept) begin
        cand_q    <= w_cand;
        eff_dir_q <= w_eff_dir;
        grow_q    <= w_grow;
        limit_q   <= w_limit;
        idx_q     <= '0;
      end else if (state_q == ST_CHECK) begin
        idx_q <= idx_q + C_ONE;
      end
      if (w_commit) begin
        last_dir_q <= eff_dir_q;
        if (grow_q) begin
          len_q <= len_q + C_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_q[0] <= C_START;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_q[i] <= '0;
      end
    end else if (w_commit) begin
      seg_q[0] <= cand_q;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_q[i] <= seg_q[i-1];
      end
    end
  end

  // Out-of-range indices read as zero so the port never selects past the buffer.
  assign rd_seg_o   = (rd_idx_i < C_MAX_LEN) ? seg_q[rd_idx_i[AW-1:0]] : '0;
  assign rd_valid_o = (rd_idx_i < len_q);

  assign ready_o = (state_q == ST_RUN);
  assign alive_o = (state_q != ST_DEAD);
  assign done_o  = done_q;
  assign dead_o  = dead_q;
  assign head_o  = seg_q[0];
  assign len_o   = len_q;

endmodule : snk_body
`default_nettype wire

// File: doc/snk_body.md
Name: snk_body

Overview:
Parametrised successor to the single-head snake mover. Holds the full snake body as a shift buffer of up to MAX_LEN packed {x,y} segments. Applies a direction on each accepted step, with reversal guard, wall or wrap handling, and a sequential self-collision scan. Sits between the input/direction logic and the display/food logic; exposes a random-access read port for rendering.

Parameters:
BITS, 4, width of one coordinate; grid is 2^BITS x 2^BITS; segment = {x[BITS-1:0], y[BITS-1:0]}
MAX_LEN, 16, maximum segment count (>=2)
WRAP, 0, 0 = edge hit kills snake; 1 = coordinates wrap modulo 2^BITS
START_X, 2^(BITS-1), reset head x
START_Y, 2^(BITS-1), reset head y
IW (localparam), clog2(MAX_LEN+1), width of len and rd_idx

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous, active-high reset
step  in  1  request one move; sampled only when ready=1
dir  in  2  00 y-1, 01 y+1, 10 x-1, 11 x+1
grow  in  1  sampled with accepted step; that move keeps the tail
ready  out  1  high in RUN only
done  out  1  1-cycle pulse, move committed
dead  out  1  1-cycle pulse, death detected
alive  out  1  low from death until RST
head  out  2*BITS  seg[0]
len  out  IW  current length, 1..MAX_LEN
rd_idx  in  IW  read index
rd_seg  out  2*BITS  seg[rd_idx], combinational
rd_valid  out  1  rd_idx < len

Behaviour:
- Reset (takes priority in any state, incl. mid-CHECK): seg[0]={START_X,START_Y}, other segs 0, len=1, last_dir=11, alive=1, done=dead=0, state RUN. Pending move discarded.
- FSM states: RUN, CHECK, COMMIT, DEAD.
- RUN, step=1 (edge E0):
  - eff_dir = last_dir if dir is the opposite of last_dir and len>1; otherwise dir.
  - cand = seg[0] moved by eff_dir.
  - WRAP=0 and the move leaves the grid (x=0 with 10, x=max with 11, y=0 with 00, y=max with 01): go to DEAD, dead=1.
  - WRAP=1: cand wraps with plain modular BITS-bit arithmetic.
  - Otherwise latch cand, eff_dir, and g = grow & (len<MAX_LEN). grow at MAX_LEN is ignored.
  - limit = len-1 if g=0, len if g=1. The tail vacates the cell unless growing.
  - limit=0: go to COMMIT. Otherwise go to CHECK with idx=0.
- CHECK: compare cand with seg[idx], one segment per cycle.
  - Match: go to DEAD, dead=1, no commit.
  - idx=limit-1 with no match: go to COMMIT. Otherwise idx+1.
  - step is ignored.
- COMMIT: seg[i]<=seg[i-1] for i=1..MAX_LEN-1; seg[0]<=cand; last_dir<=eff_dir; len+=g; done=1; go to RUN.
- Latency from accepting edge to head/len update and done: limit+2 edges.
- DEAD: alive=0, ready=0, step ignored, body frozen. Exit only via RST.
- done and dead are never both high in the same cycle. Neither is high in the cycle after RST.
- rd_seg returns the stored value even when rd_valid=0. Consumers must qualify with rd_valid.
- step while ready=0 is dropped, not queued.

Decomposition:
- Package snk_pkg: direction constants (DIR_UP=00, DIR_DN=01, DIR_LT=10, DIR_RT=11), opposite-direction function, FSM state enum, segment pack/unpack helpers.
- Sub-module snk_next_pos (combinational): inputs head, dir, last_dir, len; outputs cand, eff_dir, wall_hit. Parametrised on BITS and WRAP.
- Body buffer and FSM stay in snk_body.

Test Plan:
1. BITS=4, reset, step dir=11, grow=0 -> 2 edges later head=(9,8), len=1, done for exactly 1 cycle; ready low in between.
2. WRAP=0, drive head to (15,8), step dir=11 -> dead pulse, alive=0, head stays (15,8); later steps give no done.
3. WRAP=1, head (15,8) dir=11 -> head=(0,8); head (0,0) dir=00 -> head=(0,15).
4. Four steps right with grow=1 -> len=5; rd_idx 0..4 return (12,8),(11,8),(10,8),(9,8),(8,8), rd_valid=0 at idx 5; then step dir=10 -> reversal ignored, head=(13,8); fifth step latency = 4+2 edges.
5. Self-collision: len=5 snake, moves 00,10,01 (up, left, down) -> cand hits body -> dead during CHECK. Tail-chase: len=4 closed 2x2 loop with grow=0 -> survives, done each move.
6. Assert RST during CHECK (len=5) -> next edge head=(8,8), len=1, ready=1, no done/dead pulse; MAX_LEN saturation: grow held at len=16 -> len stays 16.
